sram_controller: RTL and testbench
==================================

# sram_controller

Bridges the ARM pipeline's memory stage to the external 16-bit asynchronous SRAM. It accepts one 32-bit word read or write from the MEM stage and performs it as two consecutive 16-bit SRAM accesses, low half first. It drives the SRAM address, data and control pins. While an access is in progress it holds `ready` low so the pipeline freezes.

## Interface
- `ADDR_LEN`, default `SRAM_ADDR_LEN` (18): SRAM address width.
- `DATA_LEN`, default `SRAM_DATA_LEN` (16): SRAM data width.
- `ACCESS_CYCLES`, default 3: clk cycles each half-word access is held on the pins (≥1).

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: word write request from the MEM stage. Held stable while `ready`=0.
- `rd_en` in 1: word read request. Held stable while `ready`=0.
- `address` in 32: byte address. Word index = `address[18:2]`.
- `write_data` in 32: word to store.
- `read_data` out 32: last word read.
- `ready` out 1: 0 freezes the pipeline.
- `SRAM_DQ` inout `DATA_LEN`: bidirectional data. High-Z unless writing.
- `SRAM_ADDR` out `ADDR_LEN`: half-word address.
- `SRAM_WE_N` out 1: write enable, active low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: constant 0.

## Operation
- State machine states: IDLE, LOW, HIGH, DONE. Phase counter `cnt` runs 0..`ACCESS_CYCLES`-1.
- **IDLE**
  - If `wr_en|rd_en` = 1: latch op (`wr_en` has priority when both are 1), `address` and `write_data`; clear `cnt`; go to LOW.
  - Otherwise stay in IDLE.
- **LOW**
  - `SRAM_ADDR = {word_index, 1'b0}`.
  - Write: `SRAM_DQ` = latched `write_data[15:0]`, `SRAM_WE_N`=0.
  - Read: `SRAM_DQ` = Z, `SRAM_WE_N`=1.
  - On the edge where `cnt`=`ACCESS_CYCLES`-1:
    - a read captures `SRAM_DQ` into `read_data[15:0]`;
    - `cnt` clears and the state moves to HIGH.
  - Otherwise `cnt`++.
- **HIGH**
  - Same as LOW, with `SRAM_ADDR = {word_index, 1'b1}` and data half `[31:16]`.
  - On the final edge: a read captures into `read_data[31:16]`; go to DONE.
- **DONE**
  - One cycle, then go to IDLE.
  - Pins idle.
- **Idle pin values** (IDLE and DONE): `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ`=Z.
- **`ready`** = `(state==DONE) | (state==IDLE & ~(wr_en|rd_en))`.
- **Address wrap**: `address` bits above 18 are ignored, so addresses wrap modulo 512 KiB.
- **`read_data`** holds its value until the next read overwrites it. Writes never change it.
- **Request dropped mid-access** (`wr_en`/`rd_en` deasserted in LOW/HIGH): the access completes using the latched values; it is not aborted.
- **Reset**
  - Applies in any state, including mid-write: next edge goes to IDLE, with `cnt`=0 and `read_data`=0.
  - `SRAM_WE_N`=1 and `SRAM_DQ`=Z from that edge on.
  - A partial write leaves the SRAM contents undefined for that word.

## Timing
- Let cycle 0 be the first cycle with a request while in IDLE, and C = `ACCESS_CYCLES`.

| Cycles | State | `ready` |
|---|---|---|
| 0 | IDLE | 0 |
| 1..C | LOW | 0 |
| C+1..2C | HIGH | 0 |
| 2C+1 | DONE | 1 |

- Default C=3: `ready` returns 7 cycles after the request appears, and the pipeline is frozen for 7 cycles.
- `read_data` is valid throughout the DONE cycle.
- Back-to-back requests:
  - The pipeline advances on the DONE edge.
  - A new request presented in the following IDLE cycle starts immediately.
  - There is one IDLE cycle between accesses.
- `SRAM_ADDR`, `SRAM_WE_N` and `SRAM_DQ` drive are decoded from registered state and stay stable for all C cycles of a phase.
- Data is sampled at the end of the phase, after ≥C-1 cycles of settle.
- No request present: `ready`=1 combinationally. No pin activity.

## Test plan
- **Write then read**: write `0xDEADBEEF` to `address` `0x00000010` (C=3).
  - `SRAM_ADDR` shows 8 then 9, with `SRAM_WE_N`=0 for 3 cycles each.
  - `SRAM_DQ` carries `0xBEEF` then `0xDEAD`.
  - `ready`=1 at cycle 7.
  - A following read of `0x10` returns `0xDEADBEEF` at DONE.
- **Back-to-back**: write A=`0x11112222` to `0x20`, then read `0x20` the cycle after DONE.
  - Exactly one IDLE cycle separates the accesses.
  - The read returns `0x11112222`.
- **Simultaneous `rd_en`=`wr_en`=1** with `write_data`=`0xCAFEF00D`:
  - A write is performed.
  - `read_data` is unchanged.
  - A later read returns `0xCAFEF00D`.
- **Reset mid-write**: assert `rst` in HIGH, cycle C+2.
  - Next edge: IDLE, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `read_data`=0.
  - With no request, `ready`=1 after `rst` drops.
- **Address wrap**: write `0x5A5A5A5A` to `0x00080010`, then read `0x00000010`.
  - The read returns `0x5A5A5A5A`.
  - `SRAM_ADDR` is 8/9 for both accesses.
- **Request dropped in LOW**: deassert `rd_en` at cycle 2.
  - The FSM still completes through DONE.
  - `read_data` is updated with the stored word.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: bridges one 32-bit MEM-stage word access to a 16-bit
// asynchronous SRAM as two back-to-back half-word accesses, low half first.
// The pipeline is frozen (ready=0) from the request cycle until DONE.
module sram_controller #(
    parameter int ADDR_LEN      = 18,
    parameter int DATA_LEN      = 16,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    inout  wire  [DATA_LEN-1:0] SRAM_DQ,
    output logic [ADDR_LEN-1:0] SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam int IDX_W = ADDR_LEN - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 op_write;
    logic [IDX_W-1:0]     word_index;
    logic [31:0]          wdata_lat;
    logic                 request;
    logic                 phase_last;
    logic                 dq_oe;
    logic [DATA_LEN-1:0]  dq_out;
    logic                 unused_addr_bits;

    assign request    = wr_en | rd_en;
    assign phase_last = (cnt == CNT_LAST);

    // Byte-lane and low-order address bits are outside the SRAM window; the
    // window wraps every 512 KiB because the high bits are simply dropped.
    assign unused_addr_bits = ^{address[31:ADDR_LEN+1], address[1:0]};

    // State register; reset returns to IDLE from any state, even mid-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and phase-counter logic: each half-word phase lasts
    // ACCESS_CYCLES clocks, then DONE gives the pipeline one cycle to advance.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (request) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    cnt_next   = '0;
                    next_state = HIGH;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (phase_last) begin
                    cnt_next   = '0;
                    next_state = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_next   = '0;
                next_state = IDLE;
            end
            default: begin
                cnt_next   = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Pin decode from registered state only, so address, write strobe and
    // data drive stay glitch-free and stable for a whole phase.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            LOW: begin
                SRAM_ADDR = {word_index, 1'b0};
                SRAM_WE_N = ~op_write;
                dq_oe     = op_write;
                dq_out    = wdata_lat[DATA_LEN-1:0];
            end
            HIGH: begin
                SRAM_ADDR = {word_index, 1'b1};
                SRAM_WE_N = ~op_write;
                dq_oe     = op_write;
                dq_out    = wdata_lat[2*DATA_LEN-1:DATA_LEN];
            end
            default: begin
                SRAM_ADDR = '0;
                SRAM_WE_N = 1'b1;
                dq_oe     = 1'b0;
                dq_out    = '0;
            end
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {DATA_LEN{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign ready = (state == DONE) | ((state == IDLE) & ~request);

    // Datapath: latch the request on acceptance so a request dropped
    // mid-access still completes, and capture each read half at the end of
    // its phase after the SRAM output has had time to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            read_data  <= '0;
            op_write   <= 1'b0;
            word_index <= '0;
            wdata_lat  <= '0;
        end else begin
            cnt <= cnt_next;
            if ((state == IDLE) && request) begin
                op_write   <= wr_en;
                word_index <= address[ADDR_LEN:2];
                wdata_lat  <= write_data;
            end
            if ((state == LOW) && phase_last && !op_write) begin
                read_data[DATA_LEN-1:0] <= SRAM_DQ;
            end
            if ((state == HIGH) && phase_last && !op_write) begin
                read_data[2*DATA_LEN-1:DATA_LEN] <= SRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: drives word accesses into sram_controller, models the
// external SRAM as a plain array, and checks pin traces, ready latency and
// read data against a word-level reference memory.
module tb_sram_controller;

    localparam int C   = 3;
    localparam int LAT = 2 * C + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] sram_mem [0:262143];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] exp_rdata;

    logic [17:0] tr_addr  [0:63];
    logic        tr_we    [0:63];
    logic [15:0] tr_dq    [0:63];
    logic        tr_ready [0:63];

    always #5 clk = ~clk;

    sram_controller #(
        .ADDR_LEN     (18),
        .DATA_LEN     (16),
        .ACCESS_CYCLES(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    // Asynchronous SRAM model: drives the bus whenever it is not being written.
    assign sram_dq = (sram_we_n && !sram_oe_n && !sram_ce_n) ? sram_mem[sram_addr] : 16'hzzzz;

    // SRAM write: the word settles into the array while WE_N is held low.
    always @(posedge clk) begin
        if (!sram_we_n && !sram_ce_n) begin
            sram_mem[sram_addr] <= sram_dq;
        end
    end

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return a[18:2];
    endfunction

    // Word-level reference: a write stores the word, a read returns it.
    task automatic model_access(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wdata);
        logic [16:0] idx;
        idx = word_of(addr);
        if (wr) begin
            ref_mem[idx] = wdata;
        end else if (rd) begin
            exp_rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        end
    endtask

    // Expected pins for cycle k of an access (cycle 0 = request seen in IDLE).
    function automatic void expect_pins(input int k, input logic is_wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, output logic [17:0] ea,
                                        output logic ewe, output logic edrv, output logic [15:0] edq);
        ea = 18'h0; ewe = 1'b1; edrv = 1'b0; edq = 16'h0;
        if (k >= 1 && k <= C) begin
            ea = {word_of(addr), 1'b0}; ewe = !is_wr; edrv = is_wr; edq = wdata[15:0];
        end else if (k >= C + 1 && k <= 2 * C) begin
            ea = {word_of(addr), 1'b1}; ewe = !is_wr; edrv = is_wr; edq = wdata[31:16];
        end
    endfunction

    // Present one request at the next falling edge and record the pins every
    // cycle until ready returns; requests are withdrawn in the DONE cycle.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input int drop_cycle,
                              output int lat, output logic [31:0] rdata_done);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = wdata;
        lat = -1;
        rdata_done = 32'h0;
        for (int k = 0; k < 64; k++) begin
            #1;
            tr_addr[k] = sram_addr; tr_we[k] = sram_we_n; tr_dq[k] = sram_dq; tr_ready[k] = ready;
            if (k == drop_cycle) begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            if (ready && k > 0) begin
                lat = k;
                rdata_done = read_data;
                break;
            end
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        if (lat < 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_compared++;
        if (read_data !== 32'h0) begin
            n_mismatched++; $display("[TB] FAIL reset_read_data: got %h expected %h", read_data, 32'h0);
        end
        n_compared++;
        if (sram_we_n !== 1'b1 || sram_addr !== 18'h0) begin
            n_mismatched++; $display("[TB] FAIL reset_pins: got we_n=%b addr=%h expected we_n=1 addr=0", sram_we_n, sram_addr);
        end
        n_compared++;
        if ({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n} !== 4'b0000) begin
            n_mismatched++; $display("[TB] FAIL const_pins: got %b expected 0000", {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n});
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_compared++;
        if (ready !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL idle_ready: got %b expected 1", ready);
        end
        exp_rdata = 32'h0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rdv; logic [17:0] ea; logic ewe, edrv; logic [15:0] edq;
        run_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, -1, lat, rdv);
        model_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        n_compared++;
        if (lat !== LAT) begin
            n_mismatched++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, LAT);
        end
        n_compared++;
        if (tr_ready[0] !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL wr_ready_cycle0: got %b expected 0", tr_ready[0]);
        end
        for (int k = 0; k <= LAT; k++) begin
            expect_pins(k, 1'b1, 32'h10, 32'hDEADBEEF, ea, ewe, edrv, edq);
            n_compared++;
            if (tr_addr[k] !== ea || tr_we[k] !== ewe || (edrv && tr_dq[k] !== edq)) begin
                n_mismatched++;
                $display("[TB] FAIL wr_pins[%0d]: got addr=%h we_n=%b dq=%h expected addr=%h we_n=%b dq=%h",
                         k, tr_addr[k], tr_we[k], tr_dq[k], ea, ewe, edq);
            end
        end
        n_compared++;
        if (rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL wr_keeps_read_data: got %h expected %h", rdv, exp_rdata);
        end
        run_access(1'b0, 1'b1, 32'h10, 32'h0, -1, lat, rdv);
        model_access(1'b0, 1'b1, 32'h10, 32'h0);
        n_compared++;
        if (lat !== LAT || rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL rd_after_wr: got lat=%0d data=%h expected lat=%0d data=%h", lat, rdv, LAT, exp_rdata);
        end
        n_compared++;
        if (tr_addr[1] !== 18'd8 || tr_addr[C + 1] !== 18'd9 || tr_we[1] !== 1'b1 || tr_we[C + 1] !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL rd_pins: got addr=%h/%h we_n=%b/%b expected addr=8/9 we_n=1/1",
                                     tr_addr[1], tr_addr[C + 1], tr_we[1], tr_we[C + 1]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rdv;
        run_access(1'b1, 1'b0, 32'h20, 32'h11112222, -1, lat, rdv);
        model_access(1'b1, 1'b0, 32'h20, 32'h11112222);
        run_access(1'b0, 1'b1, 32'h20, 32'h0, -1, lat, rdv);
        model_access(1'b0, 1'b1, 32'h20, 32'h0);
        n_compared++;
        if (lat !== LAT || tr_ready[0] !== 1'b0 || tr_addr[0] !== 18'h0 || tr_addr[1] !== {word_of(32'h20), 1'b0}) begin
            n_mismatched++; $display("[TB] FAIL b2b_start: got lat=%0d ready0=%b addr0=%h addr1=%h expected lat=%0d ready0=0 addr0=0 addr1=%h",
                                     lat, tr_ready[0], tr_addr[0], tr_addr[1], LAT, {word_of(32'h20), 1'b0});
        end
        n_compared++;
        if (rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL b2b_data: got %h expected %h", rdv, exp_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int lat; logic [31:0] rdv;
        run_access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, -1, lat, rdv);
        model_access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
        n_compared++;
        if (tr_we[1] !== 1'b0 || tr_dq[1] !== 16'hF00D || tr_dq[C + 1] !== 16'hCAFE) begin
            n_mismatched++; $display("[TB] FAIL both_is_write: got we_n=%b dq=%h/%h expected we_n=0 dq=f00d/cafe", tr_we[1], tr_dq[1], tr_dq[C + 1]);
        end
        n_compared++;
        if (rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL both_read_data: got %h expected %h", rdv, exp_rdata);
        end
        run_access(1'b0, 1'b1, 32'h30, 32'h0, -1, lat, rdv);
        model_access(1'b0, 1'b1, 32'h30, 32'h0);
        n_compared++;
        if (rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL both_readback: got %h expected %h", rdv, exp_rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; address = 32'h40; write_data = $urandom();
        repeat (C + 2) @(negedge clk);
        #1;
        n_compared++;
        if (sram_we_n !== 1'b0 || sram_addr !== {word_of(32'h40), 1'b1}) begin
            n_mismatched++; $display("[TB] FAIL mid_write_pins: got we_n=%b addr=%h expected we_n=0 addr=%h", sram_we_n, sram_addr, {word_of(32'h40), 1'b1});
        end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        #1;
        n_compared++;
        if (sram_we_n !== 1'b1 || sram_addr !== 18'h0 || sram_dq !== sram_mem[0]) begin
            n_mismatched++; $display("[TB] FAIL rst_pins: got we_n=%b addr=%h dq=%h expected we_n=1 addr=0 dq=%h", sram_we_n, sram_addr, sram_dq, sram_mem[0]);
        end
        n_compared++;
        if (read_data !== 32'h0) begin
            n_mismatched++; $display("[TB] FAIL rst_read_data: got %h expected 0", read_data);
        end
        ref_mem.delete(word_of(32'h40));
        exp_rdata = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_compared++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL rst_ready: got ready=%b we_n=%b expected ready=1 we_n=1", ready, sram_we_n);
        end
    endtask

    task automatic test_address_wrap();
        int lat; logic [31:0] rdv;
        run_access(1'b1, 1'b0, 32'h00080010, 32'h5A5A5A5A, -1, lat, rdv);
        model_access(1'b1, 1'b0, 32'h00080010, 32'h5A5A5A5A);
        n_compared++;
        if (tr_addr[1] !== 18'd8 || tr_addr[C + 1] !== 18'd9) begin
            n_mismatched++; $display("[TB] FAIL wrap_wr_addr: got %h/%h expected 8/9", tr_addr[1], tr_addr[C + 1]);
        end
        run_access(1'b0, 1'b1, 32'h00000010, 32'h0, -1, lat, rdv);
        model_access(1'b0, 1'b1, 32'h00000010, 32'h0);
        n_compared++;
        if (tr_addr[1] !== 18'd8 || tr_addr[C + 1] !== 18'd9) begin
            n_mismatched++; $display("[TB] FAIL wrap_rd_addr: got %h/%h expected 8/9", tr_addr[1], tr_addr[C + 1]);
        end
        n_compared++;
        if (rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL wrap_data: got %h expected %h", rdv, exp_rdata);
        end
    endtask

    task automatic test_drop_request();
        int lat; logic [31:0] rdv;
        run_access(1'b0, 1'b1, 32'h20, 32'h0, 2, lat, rdv);
        model_access(1'b0, 1'b1, 32'h20, 32'h0);
        n_compared++;
        if (lat !== LAT || rdv !== exp_rdata) begin
            n_mismatched++; $display("[TB] FAIL drop_read: got lat=%0d data=%h expected lat=%0d data=%h", lat, rdv, LAT, exp_rdata);
        end
        @(negedge clk);
        #1;
        n_compared++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'h0) begin
            n_mismatched++; $display("[TB] FAIL drop_then_idle: got ready=%b we_n=%b addr=%h expected 1/1/0", ready, sram_we_n, sram_addr);
        end
    endtask

    task automatic test_random();
        logic [16:0] pool [0:7];
        int lat; int drop; logic [31:0] rdv; logic [31:0] r; logic [31:0] addr; logic [31:0] wdata;
        logic wr, rd; logic [17:0] ea; logic ewe, edrv; logic [15:0] edq; int bad;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 17'($urandom_range(64, 4000));
            addr = {15'h0, pool[i], 2'b00};
            wdata = $urandom();
            run_access(1'b1, 1'b0, addr, wdata, -1, lat, rdv);
            model_access(1'b1, 1'b0, addr, wdata);
        end
        for (int n = 0; n < 24; n++) begin
            r = $urandom();
            addr = {r[31:19], pool[$urandom_range(0, 7)], r[1:0]};
            wdata = $urandom();
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * C)) : -1;
            run_access(wr, rd, addr, wdata, drop, lat, rdv);
            model_access(wr, rd, addr, wdata);
            n_compared++;
            if (lat !== LAT || rdv !== exp_rdata) begin
                n_mismatched++; $display("[TB] FAIL rand_op[%0d]: wr=%b addr=%h got lat=%0d data=%h expected lat=%0d data=%h",
                                         n, wr, addr, lat, rdv, LAT, exp_rdata);
            end
            bad = 0;
            for (int k = 0; k <= LAT; k++) begin
                expect_pins(k, wr, addr, wdata, ea, ewe, edrv, edq);
                if (tr_addr[k] !== ea || tr_we[k] !== ewe || (edrv && tr_dq[k] !== edq)) begin
                    bad++;
                end
            end
            n_compared++;
            if (bad != 0) begin
                n_mismatched++; $display("[TB] FAIL rand_pins[%0d]: wr=%b addr=%h got %0d bad cycles expected 0", n, wr, addr, bad);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
        exp_rdata = 32'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_write();
        test_address_wrap();
        test_drop_request();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
